// File: rtl/iir_coef_ctrl.sv
// Coefficient and flow controller between the sample source and the IIR filter.
// Host writes land in a shadow bank; a commit drains the filter and swaps banks atomically.
module iir_coef_ctrl #(
  parameter int N         = 8,
  parameter int MAX_INFL  = 4,
  parameter int DRAIN_MAX = 64,
  parameter int B0_RST    = 53,
  parameter int B1_RST    = 53,
  parameter int A1_RST    = 21
) (
  input  logic           CLK,
  input  logic           RST_n,
  input  logic           S_VIN,
  input  logic [N-1:0]   S_DIN,
  output logic           S_READY,
  output logic           F_VIN,
  output logic [N-1:0]   F_DIN,
  input  logic           F_VOUT,
  output logic [2*N-1:0] F_B,
  output logic [N-1:0]   F_A,
  input  logic           CFG_WE,
  input  logic [1:0]     CFG_ADDR,
  input  logic [N-1:0]   CFG_WDATA,
  input  logic           CFG_COMMIT,
  output logic           CFG_BUSY,
  output logic           SWAP_DONE,
  output logic [1:0]     ERR
);

  localparam int IW = $clog2(MAX_INFL + 1);
  localparam int DW = $clog2(DRAIN_MAX + 1);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HOLD = 2'd1,
    SWAP = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [IW-1:0] infl_q, infl_d;
  logic [DW-1:0] drain_q, drain_d;
  logic [1:0]    err_q, err_d;
  logic          swap_done_q, swap_done_d;

  logic [N-1:0] b0_sh_q, b0_sh_d;
  logic [N-1:0] b1_sh_q, b1_sh_d;
  logic [N-1:0] a1_sh_q, a1_sh_d;
  logic [N-1:0] b0_act_q, b0_act_d;
  logic [N-1:0] b1_act_q, b1_act_d;
  logic [N-1:0] a1_act_q, a1_act_d;

  logic s_ready;
  logic cfg_busy;
  logic do_swap;
  logic force_swap;
  logic f_vin;
  logic inc;
  logic dec;
  logic cnt_err;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // HOLD leaves as soon as the filter is empty, or after DRAIN_MAX cycles regardless.
  always_comb begin
    state_d    = state_q;
    force_swap = 1'b0;
    case (state_q)
      RUN: begin
        if (CFG_COMMIT) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (infl_q == '0) begin
          state_d = SWAP;
        end else if (drain_q == DW'(DRAIN_MAX - 1)) begin
          state_d    = SWAP;
          force_swap = 1'b1;
        end
      end
      SWAP: begin
        state_d = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_comb begin
    s_ready  = (state_q == RUN);
    cfg_busy = (state_q != RUN);
    do_swap  = (state_q == SWAP);
  end

  assign f_vin     = S_VIN & s_ready;
  assign S_READY   = s_ready;
  assign CFG_BUSY  = cfg_busy;
  assign F_VIN     = f_vin;
  assign F_DIN     = S_DIN;
  assign F_B       = {b1_act_q, b0_act_q};
  assign F_A       = a1_act_q;
  assign SWAP_DONE = swap_done_q;
  assign ERR       = err_q;

  // Simultaneous accept and retire cancel out; out-of-range moves saturate and flag ERR[0].
  always_comb begin
    infl_d  = infl_q;
    cnt_err = 1'b0;
    inc     = f_vin & ~F_VOUT;
    dec     = F_VOUT & ~f_vin;
    if (inc) begin
      if (infl_q == IW'(MAX_INFL)) begin
        cnt_err = 1'b1;
      end else begin
        infl_d = infl_q + 1'b1;
      end
    end else if (dec) begin
      if (infl_q == '0) begin
        cnt_err = 1'b1;
      end else begin
        infl_d = infl_q - 1'b1;
      end
    end
  end

  always_comb begin
    drain_d = drain_q;
    if (state_q == RUN && CFG_COMMIT) begin
      drain_d = '0;
    end else if (state_q == HOLD) begin
      drain_d = drain_q + 1'b1;
    end
  end

  always_comb begin
    err_d       = err_q | {force_swap, cnt_err};
    swap_done_d = do_swap;
  end

  // Active copies the registered shadow, so a write landing in the SWAP cycle waits for the next commit.
  always_comb begin
    b0_sh_d  = b0_sh_q;
    b1_sh_d  = b1_sh_q;
    a1_sh_d  = a1_sh_q;
    b0_act_d = b0_act_q;
    b1_act_d = b1_act_q;
    a1_act_d = a1_act_q;
    if (CFG_WE) begin
      case (CFG_ADDR)
        2'd0:    b0_sh_d = CFG_WDATA;
        2'd1:    b1_sh_d = CFG_WDATA;
        2'd2:    a1_sh_d = CFG_WDATA;
        default: ;
      endcase
    end
    if (do_swap) begin
      b0_act_d = b0_sh_q;
      b1_act_d = b1_sh_q;
      a1_act_d = a1_sh_q;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      infl_q      <= '0;
      drain_q     <= '0;
      err_q       <= '0;
      swap_done_q <= 1'b0;
      b0_sh_q     <= N'(B0_RST);
      b1_sh_q     <= N'(B1_RST);
      a1_sh_q     <= N'(A1_RST);
      b0_act_q    <= N'(B0_RST);
      b1_act_q    <= N'(B1_RST);
      a1_act_q    <= N'(A1_RST);
    end else begin
      infl_q      <= infl_d;
      drain_q     <= drain_d;
      err_q       <= err_d;
      swap_done_q <= swap_done_d;
      b0_sh_q     <= b0_sh_d;
      b1_sh_q     <= b1_sh_d;
      a1_sh_q     <= a1_sh_d;
      b0_act_q    <= b0_act_d;
      b1_act_q    <= b1_act_d;
      a1_act_q    <= a1_act_d;
    end
  end

endmodule

// File: tb/tb_iir_coef_ctrl.sv
// Directed bench for iir_coef_ctrl with a latency-2 filter model and an in-order scoreboard
// holding {sample, b1, b0, a1} expected at each filter output.
module tb_iir_coef_ctrl;

  logic        CLK;
  logic        RST_n;
  logic        S_VIN;
  logic [7:0]  S_DIN;
  logic        S_READY;
  logic        F_VIN;
  logic [7:0]  F_DIN;
  logic        F_VOUT;
  logic [15:0] F_B;
  logic [7:0]  F_A;
  logic        CFG_WE;
  logic [1:0]  CFG_ADDR;
  logic [7:0]  CFG_WDATA;
  logic        CFG_COMMIT;
  logic        CFG_BUSY;
  logic        SWAP_DONE;
  logic [1:0]  ERR;

  int total = 0;
  int bad   = 0;

  logic [31:0] sb[$];
  logic        filt_en = 1'b1;
  int          spur_cnt = 0;

  iir_coef_ctrl dut (
    .CLK        (CLK),
    .RST_n      (RST_n),
    .S_VIN      (S_VIN),
    .S_DIN      (S_DIN),
    .S_READY    (S_READY),
    .F_VIN      (F_VIN),
    .F_DIN      (F_DIN),
    .F_VOUT     (F_VOUT),
    .F_B        (F_B),
    .F_A        (F_A),
    .CFG_WE     (CFG_WE),
    .CFG_ADDR   (CFG_ADDR),
    .CFG_WDATA  (CFG_WDATA),
    .CFG_COMMIT (CFG_COMMIT),
    .CFG_BUSY   (CFG_BUSY),
    .SWAP_DONE  (SWAP_DONE),
    .ERR        (ERR)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One-cycle pulse of the host/source inputs, entered and left at a falling edge.
  task automatic applyStimulus(input logic we, input logic [1:0] addr, input logic [7:0] wdata,
                               input logic commit, input logic svin, input logic [7:0] sdin);
    CFG_WE     = we;
    CFG_ADDR   = addr;
    CFG_WDATA  = wdata;
    CFG_COMMIT = commit;
    S_VIN      = svin;
    S_DIN      = sdin;
    @(negedge CLK);
    CFG_WE     = 1'b0;
    CFG_COMMIT = 1'b0;
    S_VIN      = 1'b0;
  endtask

  // Commits and counts stalled cycles; returns at the falling edge of the first ready cycle.
  task automatic measureCommit(output int stall);
    CFG_COMMIT = 1'b1;
    @(negedge CLK);
    CFG_COMMIT = 1'b0;
    stall = 0;
    while (S_READY !== 1'b1 && stall < 200) begin
      stall++;
      @(negedge CLK);
    end
  endtask

  // Filter model: output valid two cycles after each accepted input, checked against the scoreboard.
  initial begin
    logic        v0, v1, vreal, spur;
    logic [31:0] d0, d1, dout, exp;
    int          spur_seen;
    v0 = 1'b0; v1 = 1'b0; vreal = 1'b0; spur = 1'b0;
    d0 = '0; d1 = '0; dout = '0; spur_seen = 0;
    F_VOUT = 1'b0;
    forever begin
      @(posedge CLK);
      if (F_VOUT === 1'b1 && vreal) begin
        checkOutput("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          exp = sb.pop_front();
          checkOutput("filt_input_tuple", dout, exp);
          checkOutput("coef_at_output", {8'h00, F_B, F_A}, {8'h00, exp[23:0]});
        end
      end
      v1 = v0;
      d1 = d0;
      v0 = (F_VIN === 1'b1);
      d0 = {F_DIN, F_B, F_A};
      #2;
      spur = (spur_cnt != spur_seen);
      spur_seen = spur_cnt;
      vreal  = v1 & filt_en;
      dout   = d1;
      F_VOUT = vreal | spur;
    end
  end

  initial begin
    int stall;
    int pulses;
    int w;
    int waits[8];
    logic acc;
    logic [7:0] x;

    RST_n = 1'b0; S_VIN = 1'b0; S_DIN = '0;
    CFG_WE = 1'b0; CFG_ADDR = '0; CFG_WDATA = '0; CFG_COMMIT = 1'b0;

    repeat (2) @(negedge CLK);
    checkOutput("rst_ready", 32'(S_READY), 32'd1);
    checkOutput("rst_busy", 32'(CFG_BUSY), 32'd0);
    RST_n = 1'b1;
    repeat (2) @(negedge CLK);
    checkOutput("idle_fb", 32'(F_B), 32'h3535);
    checkOutput("idle_fa", 32'(F_A), 32'h15);
    checkOutput("idle_err", 32'(ERR), 32'd0);
    checkOutput("idle_swap_done", 32'(SWAP_DONE), 32'd0);

    $display("[TB] basic commit, nothing in flight");
    applyStimulus(1'b1, 2'd0, 8'd10, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 2'd1, 8'd20, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 2'd2, 8'd5,  1'b0, 1'b0, 8'h00);
    checkOutput("shadow_not_active", 32'(F_B), 32'h3535);
    measureCommit(stall);
    checkOutput("basic_stall", 32'(stall), 32'd2);
    checkOutput("basic_swap_done", 32'(SWAP_DONE), 32'd1);
    checkOutput("basic_fb", 32'(F_B), 32'h140A);
    checkOutput("basic_fa", 32'(F_A), 32'h05);
    @(negedge CLK);
    checkOutput("basic_swap_done_pulse", 32'(SWAP_DONE), 32'd0);

    $display("[TB] streaming commit with latency-2 filter");
    applyStimulus(1'b1, 2'd0, 8'd1, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 2'd1, 8'd2, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 2'd2, 8'd3, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      x = 8'(8'h40 + i);
      if (i <= 4) sb.push_back({x, 16'h140A, 8'h05});
      else        sb.push_back({x, 16'h0201, 8'h03});
      S_VIN = 1'b1;
      S_DIN = x;
      CFG_COMMIT = (i == 4);
      acc = 1'b0;
      w = 0;
      while (!acc && w < 100) begin
        @(posedge CLK);
        acc = (F_VIN === 1'b1);
        w++;
      end
      waits[i] = w;
      @(negedge CLK);
      CFG_COMMIT = 1'b0;
    end
    S_VIN = 1'b0;
    repeat (6) @(negedge CLK);
    checkOutput("stream_wait_pre", 32'(waits[3]), 32'd1);
    checkOutput("stream_wait_commit", 32'(waits[4]), 32'd1);
    checkOutput("stream_wait_held", 32'(waits[5]), 32'd5);
    checkOutput("stream_wait_post", 32'(waits[6]), 32'd1);
    checkOutput("stream_sb_drained", 32'(sb.size()), 32'd0);
    checkOutput("stream_fb", 32'(F_B), 32'h0201);
    checkOutput("stream_fa", 32'(F_A), 32'h03);

    $display("[TB] commit held through HOLD and SWAP");
    applyStimulus(1'b1, 2'd1, 8'h77, 1'b0, 1'b0, 8'h00);
    CFG_COMMIT = 1'b1;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      if (c == 3) CFG_COMMIT = 1'b0;
      @(negedge CLK);
      if (SWAP_DONE === 1'b1) pulses++;
    end
    checkOutput("hold_commit_pulses", 32'(pulses), 32'd1);
    checkOutput("hold_commit_fb", 32'(F_B), 32'h7701);

    $display("[TB] shadow write in the SWAP cycle");
    applyStimulus(1'b1, 2'd0, 8'h07, 1'b0, 1'b0, 8'h00);
    CFG_COMMIT = 1'b1;
    @(negedge CLK);
    CFG_COMMIT = 1'b0;
    @(negedge CLK);
    checkOutput("swapcyc_busy", 32'(CFG_BUSY), 32'd1);
    CFG_WE = 1'b1; CFG_ADDR = 2'd0; CFG_WDATA = 8'h63;
    @(negedge CLK);
    CFG_WE = 1'b0;
    checkOutput("swapcyc_done", 32'(SWAP_DONE), 32'd1);
    checkOutput("swapcyc_old_shadow", 32'(F_B), 32'h7707);
    measureCommit(stall);
    checkOutput("swapcyc_recommit_stall", 32'(stall), 32'd2);
    checkOutput("swapcyc_new_shadow", 32'(F_B), 32'h7763);

    $display("[TB] drain timeout with a lost filter output");
    filt_en = 1'b0;
    applyStimulus(1'b1, 2'd2, 8'h2A, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 8'hAA);
    measureCommit(stall);
    checkOutput("timeout_stall", 32'(stall), 32'd65);
    checkOutput("timeout_swap_done", 32'(SWAP_DONE), 32'd1);
    checkOutput("timeout_fa", 32'(F_A), 32'h2A);
    checkOutput("timeout_err", 32'(ERR), 32'd2);
    repeat (10) @(negedge CLK);
    checkOutput("timeout_err_sticky", 32'(ERR), 32'd2);

    $display("[TB] reset asserted during HOLD");
    applyStimulus(1'b1, 2'd0, 8'h11, 1'b0, 1'b0, 8'h00);
    CFG_COMMIT = 1'b1;
    @(negedge CLK);
    CFG_COMMIT = 1'b0;
    repeat (3) @(negedge CLK);
    checkOutput("hold_before_reset", 32'(CFG_BUSY), 32'd1);
    #2 RST_n = 1'b0;
    #1;
    checkOutput("async_rst_ready", 32'(S_READY), 32'd1);
    checkOutput("async_rst_busy", 32'(CFG_BUSY), 32'd0);
    checkOutput("async_rst_coef", {8'h00, F_B, F_A}, 32'h00353515);
    checkOutput("async_rst_err", 32'(ERR), 32'd0);
    @(negedge CLK);
    RST_n = 1'b1;
    repeat (3) @(negedge CLK);
    filt_en = 1'b1;
    measureCommit(stall);
    checkOutput("post_rst_stall", 32'(stall), 32'd2);
    checkOutput("post_rst_shadow", {8'h00, F_B, F_A}, 32'h00353515);

    $display("[TB] spurious filter output with nothing in flight");
    spur_cnt++;
    repeat (3) @(negedge CLK);
    checkOutput("spur_err", 32'(ERR), 32'd1);
    measureCommit(stall);
    checkOutput("spur_count_held", 32'(stall), 32'd2);
    checkOutput("spur_err_sticky", 32'(ERR), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
